// File: rtl/pinwheel_regfile_mh.sv
// Multi-hart register file: HARTS banks of REGS entries in one RAM array.
// Two registered read ports, one byte-masked write port with per-lane
// write-before-read bypass, optional hardwired x0 per hart, and a sweep FSM
// that zeroes the whole array after reset before raising ready.
module pinwheel_regfile_mh #(
    parameter  int HARTS    = 8,
    parameter  int REGS     = 32,
    parameter  int WIDTH    = 32,
    parameter  int ZERO_REG = 1,
    localparam int DEPTH    = HARTS * REGS,
    localparam int AW       = $clog2(DEPTH),
    localparam int RB       = $clog2(REGS),
    localparam int MB       = WIDTH / 8
) (
    input  logic             clock,
    input  logic             rst_n,
    output logic             ready,
    input  logic [AW-1:0]    raddr1,
    output logic [WIDTH-1:0] rdata1,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] rdata2,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [MB-1:0]    wmask,
    input  logic             wren
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic [WIDTH-1:0]  rdata1_q, rdata1_d;
    logic [WIDTH-1:0]  rdata2_q, rdata2_d;

    logic [WIDTH-1:0]  mem [DEPTH];

    // Array write port, shared between the sweep and the user write path.
    logic [MB-1:0]     mem_be;
    logic [AW-1:0]     mem_addr;
    logic [WIDTH-1:0]  mem_wdata;

    // Lanes actually written by the user port this cycle (zero after x0 drop).
    logic [MB-1:0]     wr_lanes;
    logic              wr_to_zero;

    assign ready  = ready_q;
    assign rdata1 = rdata1_q;
    assign rdata2 = rdata2_q;

    // Qualify the user write: RUN only, and x0 writes are dropped.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        wr_lanes   = '0;
        wr_to_zero = (ZERO_REG != 0) && (waddr[RB-1:0] == '0);
        if (state_q == ST_RUN && wren && !wr_to_zero) begin
            wr_lanes = wmask;
        end
    end

    // Sweep FSM next state, counter and array write-port steering.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_be    = '0;
        mem_addr  = waddr;
        mem_wdata = wdata;
        unique case (state_q)
            ST_CLEAR: begin
                mem_be    = '1;
                mem_addr  = cnt_q;
                mem_wdata = '0;
                cnt_d     = cnt_q + AW'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                mem_be = wr_lanes;
            end
            default: state_d = ST_CLEAR;
        endcase
        ready_d = (state_d == ST_RUN);
    end

    // Read data: array value, overlaid per lane by a same-cycle write, x0 forced to 0.
    always_comb begin
        rdata1_d = '0;
        rdata2_d = '0;
        if (state_q == ST_RUN) begin
            rdata1_d = mem[raddr1];
            rdata2_d = mem[raddr2];
            for (int b = 0; b < MB; b++) begin
                if (wr_lanes[b] && raddr1 == waddr) rdata1_d[8*b +: 8] = wdata[8*b +: 8];
                if (wr_lanes[b] && raddr2 == waddr) rdata2_d[8*b +: 8] = wdata[8*b +: 8];
            end
            if (ZERO_REG != 0 && raddr1[RB-1:0] == '0) rdata1_d = '0;
            if (ZERO_REG != 0 && raddr2[RB-1:0] == '0) rdata2_d = '0;
        end
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!rst_n) begin
            state_q  <= ST_CLEAR;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            rdata1_q <= '0;
            rdata2_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
        end
    end

    // Byte-enabled array write.
    always_ff @(posedge clock) begin
        // NOTE: the array has no reset so it maps to block RAM; the sweep FSM zeroes it instead.
        for (int b = 0; b < MB; b++) begin
            if (mem_be[b]) begin
                mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

endmodule
